// File: rtl/card_deal_ctrl_pkg.sv
// Shared card definitions: bus widths, color palette, covered-state code,
// LFSR seed, controller state encoding and small helpers.
package card_deal_ctrl_pkg;

  localparam int CARD_ADDRESS_SIZE = 5;
  localparam int CARD_COLOR_SIZE   = 4;
  localparam int CARD_STATE_SIZE   = 2;
  localparam int CARD_MAX_NUM_SIZE = 5;

  // Largest deck the memory can hold (addresses 1..30, address 0 unused).
  localparam int CARD_MAX_DECK = 30;

  localparam logic [CARD_STATE_SIZE-1:0] CARD_STATE_COVERED = 2'b01;
  localparam logic [15:0]                LFSR_SEED          = 16'hACE1;

  // One color per card pair; pair p occupies addresses 2p+1 and 2p+2 after FILL.
  localparam logic [CARD_COLOR_SIZE-1:0] PALETTE [0:14] = '{
    4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h1, 4'h2,
    4'h4, 4'h8, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF
  };

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_PICK,
    ST_RD_I,
    ST_RD_J,
    ST_RD_WAIT,
    ST_WR_I,
    ST_WR_J,
    ST_DONE
  } deal_state_e;

  function automatic logic [CARD_COLOR_SIZE-1:0] palette_color(input logic [3:0] pair_idx);
    return PALETTE[pair_idx];
  endfunction

  // Round the request down to an even count and cap it at the deck size.
  function automatic logic [CARD_ADDRESS_SIZE-1:0] clamp_card_count(
    input logic [CARD_MAX_NUM_SIZE-1:0] num
  );
    logic [CARD_ADDRESS_SIZE-1:0] even;
    even = num & 5'b11110;
    return (even > 5'(CARD_MAX_DECK)) ? 5'(CARD_MAX_DECK) : even;
  endfunction

endpackage

// File: rtl/card_deal_ctrl_if.sv
// Handshake and card-memory bus between the deal controller and its environment.
interface card_deal_ctrl_if;
  import card_deal_ctrl_pkg::*;

  logic                         start;
  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards;
  logic [CARD_COLOR_SIZE-1:0]   mem_rdata_color;
  logic                         mem_we;
  logic [CARD_ADDRESS_SIZE-1:0] mem_addr;
  logic [CARD_COLOR_SIZE-1:0]   mem_wdata_color;
  logic [CARD_STATE_SIZE-1:0]   mem_wdata_state;
  logic                         compute_done;
  logic                         busy;

  // Controller side.
  modport master (
    input  start, num_of_cards, mem_rdata_color,
    output mem_we, mem_addr, mem_wdata_color, mem_wdata_state, compute_done, busy
  );

  // Requester / memory side.
  modport slave (
    output start, num_of_cards, mem_rdata_color,
    input  mem_we, mem_addr, mem_wdata_color, mem_wdata_state, compute_done, busy
  );
endinterface

// File: rtl/card_deal_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16
  import card_deal_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting form: taps 16,14,13,11 sit at bits 0,2,3,5.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Shift every cycle; seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/card_deal_ctrl.sv
// Card deal controller: fills card memory with color pairs, then shuffles it
// in place with a Fisher-Yates pass driven by an LFSR (rejection sampling).
module card_deal_ctrl
  import card_deal_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  card_deal_ctrl_if.master bus
);

  deal_state_e                  state_q, state_d;
  logic                         start_q;
  logic [CARD_ADDRESS_SIZE-1:0] n_q, n_d;
  logic [CARD_ADDRESS_SIZE-1:0] k_q, k_d;
  logic [CARD_ADDRESS_SIZE-1:0] i_q, i_d;
  logic [CARD_ADDRESS_SIZE-1:0] j_q, j_d;
  logic [CARD_COLOR_SIZE-1:0]   color_i_q, color_i_d;
  logic [CARD_COLOR_SIZE-1:0]   color_j_q, color_j_d;

  logic [15:0]                  lfsr;
  logic                         lfsr_unused;
  logic [CARD_ADDRESS_SIZE-1:0] cand;
  logic [CARD_ADDRESS_SIZE-1:0] req_n;
  logic [3:0]                   fill_pair;
  logic                         start_rise;
  logic                         deal_busy;

  logic                         mem_we;
  logic [CARD_ADDRESS_SIZE-1:0] mem_addr;
  logic [CARD_COLOR_SIZE-1:0]   mem_wdata_color;
  logic                         compute_done;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Only the low bits feed the candidate index.
  assign lfsr_unused = ^lfsr[15:CARD_ADDRESS_SIZE];
  assign cand        = lfsr[CARD_ADDRESS_SIZE-1:0];
  assign req_n       = clamp_card_count(bus.num_of_cards);
  assign fill_pair   = 4'((k_q - 5'd1) >> 1);
  assign start_rise  = bus.start & ~start_q;
  assign deal_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Next-state and datapath update; dropping start while busy aborts the deal.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    color_i_d = color_i_q;
    color_j_d = color_j_q;
    if (deal_busy && !bus.start) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            n_d = req_n;
            if (req_n == '0) begin
              state_d = ST_DONE;
            end else begin
              k_d     = 5'd1;
              state_d = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (k_q == n_q) begin
            i_d     = n_q;
            state_d = ST_PICK;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
        ST_PICK: begin
          // Reject out-of-range candidates instead of reducing modulo i.
          if (cand < i_q) begin
            j_d     = cand + 5'd1;
            state_d = ST_RD_I;
          end
        end
        ST_RD_I:    state_d = ST_RD_J;
        ST_RD_J: begin
          color_i_d = bus.mem_rdata_color;
          state_d   = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          color_j_d = bus.mem_rdata_color;
          state_d   = ST_WR_I;
        end
        ST_WR_I:    state_d = ST_WR_J;
        ST_WR_J: begin
          i_d     = i_q - 5'd1;
          state_d = (i_q == 5'd2) ? ST_DONE : ST_PICK;
        end
        ST_DONE: begin
          if (!bus.start) state_d = ST_IDLE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Memory bus and status outputs decoded from the current state.
  always_comb begin
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata_color = '0;
    compute_done    = 1'b0;
    case (state_q)
      ST_FILL: begin
        mem_we          = bus.start;
        mem_addr        = k_q;
        mem_wdata_color = palette_color(fill_pair);
      end
      ST_RD_I: mem_addr = i_q;
      ST_RD_J: mem_addr = j_q;
      ST_WR_I: begin
        mem_we          = bus.start;
        mem_addr        = i_q;
        mem_wdata_color = color_j_q;
      end
      ST_WR_J: begin
        mem_we          = bus.start;
        mem_addr        = j_q;
        mem_wdata_color = color_i_q;
      end
      ST_DONE: compute_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_we          = mem_we;
  assign bus.mem_addr        = mem_addr;
  assign bus.mem_wdata_color = mem_wdata_color;
  assign bus.mem_wdata_state = CARD_STATE_COVERED;
  assign bus.compute_done    = compute_done;
  assign bus.busy            = deal_busy;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      n_q       <= '0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      color_i_q <= '0;
      color_j_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      n_q       <= n_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      color_i_q <= color_i_d;
      color_j_q <= color_j_d;
    end
  end

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Directed bench for card_deal_ctrl: synchronous-read card memory, LFSR
// reference, and a per-cycle check of every deal phase.
module tb_card_deal_ctrl;

  localparam logic [3:0] PAL [0:14] = '{
    4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h1, 4'h2,
    4'h4, 4'h8, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF
  };

  logic        clk;
  logic        rst;
  logic [15:0] lfsr_m;
  logic [3:0]  mem     [0:31];
  logic [3:0]  exp_mem [0:31];
  int          n_cmp;
  int          n_bad;

  card_deal_ctrl_if bus ();

  card_deal_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Card memory: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata_color;
    bus.mem_rdata_color <= mem[bus.mem_addr];
  end

  // Reference LFSR for x^16+x^14+x^13+x^11+1, seeded 16'hACE1.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(bus.mem_we), 0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_color"}, 32'(bus.mem_wdata_color), 0);
    chk({tag, "_state"}, 32'(bus.mem_wdata_state), 1);
    chk({tag, "_done"},  32'(bus.compute_done), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
  endtask

  // mode 0: full deal; 1: drop start two cycles after FILL; 2: reset in RD_WAIT.
  task automatic run_deal(input int num, input int mode);
    int n, i, j, cand, cnt, bad, hits;
    logic [3:0] guard;
    logic [3:0] tmp;
    n = num & 30;
    guard = mem[n + 1];
    bus.num_of_cards = 5'(num);
    bus.start = 1'b1;
    @(negedge clk);
    if (n == 0) begin
      chk("zero_we", 32'(bus.mem_we), 0);
    end else begin
      for (int k = 1; k <= n; k++) begin
        if (k > 1) @(negedge clk);
        chk("fill_we",    32'(bus.mem_we), 1);
        chk("fill_addr",  32'(bus.mem_addr), k);
        chk("fill_color", 32'(bus.mem_wdata_color), 32'(PAL[(k - 1) / 2]));
        chk("fill_state", 32'(bus.mem_wdata_state), 1);
        chk("fill_busy",  32'(bus.busy), 1);
        exp_mem[k] = PAL[(k - 1) / 2];
      end
      if (mode == 1) begin
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("abort_we_now", 32'(bus.mem_we), 0);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("abort_busy", 32'(bus.busy), 0);
          chk("abort_we",   32'(bus.mem_we), 0);
          chk("abort_done", 32'(bus.compute_done), 0);
        end
        return;
      end
      i = n;
      while (i > 1) begin
        cand = 32;
        cnt  = 0;
        while (cand >= i) begin
          @(negedge clk);
          chk("pick_we",   32'(bus.mem_we), 0);
          chk("pick_busy", 32'(bus.busy), 1);
          cand = int'(lfsr_m[4:0]);
          cnt++;
          if (cnt > 1000) begin
            chk("pick_timeout", cnt, 1000);
            bus.start = 1'b0;
            @(negedge clk);
            return;
          end
        end
        j = cand + 1;
        @(negedge clk);
        chk("rdi_addr", 32'(bus.mem_addr), i);
        chk("rdi_we",   32'(bus.mem_we), 0);
        @(negedge clk);
        chk("rdj_addr", 32'(bus.mem_addr), j);
        chk("rdj_we",   32'(bus.mem_we), 0);
        @(negedge clk);
        chk("rdw_we",   32'(bus.mem_we), 0);
        chk("rdw_busy", 32'(bus.busy), 1);
        if (mode == 2) begin
          rst = 1'b1;
          #1;
          chk_reset_outputs("rst_async");
          bus.start = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          #1;
          chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
          @(negedge clk);
          chk_reset_outputs("rst_idle");
          return;
        end
        @(negedge clk);
        chk("wri_we",    32'(bus.mem_we), 1);
        chk("wri_addr",  32'(bus.mem_addr), i);
        chk("wri_color", 32'(bus.mem_wdata_color), 32'(exp_mem[j]));
        @(negedge clk);
        chk("wrj_we",    32'(bus.mem_we), 1);
        chk("wrj_addr",  32'(bus.mem_addr), j);
        chk("wrj_color", 32'(bus.mem_wdata_color), 32'(exp_mem[i]));
        tmp = exp_mem[i];
        exp_mem[i] = exp_mem[j];
        exp_mem[j] = tmp;
        i--;
      end
      @(negedge clk);
    end
    chk("done_flag", 32'(bus.compute_done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_we",   32'(bus.mem_we), 0);
    chk("done_addr", 32'(bus.mem_addr), 0);
    @(negedge clk);
    chk("done_hold", 32'(bus.compute_done), 1);
    bad = 0;
    for (int a = 1; a <= n; a++) if (mem[a] !== exp_mem[a]) bad++;
    chk("mem_model", bad, 0);
    for (int p = 0; p < n / 2; p++) begin
      hits = 0;
      for (int a = 1; a <= n; a++) if (mem[a] === PAL[p]) hits++;
      chk("pair_count", hits, 2);
    end
    chk("guard_addr", 32'(mem[n + 1]), 32'(guard));
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(bus.compute_done), 0);
    chk("idle_busy",  32'(bus.busy), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_of_cards = '0;
    #1;
    chk_reset_outputs("reset");
    chk("reset_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);

    run_deal(4, 0);
    run_deal(0, 0);
    run_deal(5, 0);
    run_deal(31, 0);
    run_deal(4, 1);
    run_deal(6, 0);
    run_deal(8, 2);
    run_deal(10, 0);
    run_deal(2, 0);
    for (int r = 0; r < 50; r++) begin
      run_deal(int'($urandom_range(0, 31)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_deal_ctrl.md
CARD_DEAL_CTRL -- requirements
Module: card_deal_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  level request; high for the whole deal, from state-machine start_game_en.
REQ-004 num_of_cards  input  CARD_MAX_NUM_SIZE  requested card count; sampled on the start rising edge only.
REQ-005 mem_rdata_color  input  CARD_COLOR_SIZE  card-memory read data; valid one cycle after mem_addr is presented.
REQ-006 mem_we  output  1  card-memory write strobe; one write per high cycle.
REQ-007 mem_addr  output  CARD_ADDRESS_SIZE  card-memory read/write address; valid card addresses are 1..N, address 0 unused.
REQ-008 mem_wdata_color  output  CARD_COLOR_SIZE  color written when mem_we is high.
REQ-009 mem_wdata_state  output  CARD_STATE_SIZE  card state written; always 2'b01 (covered).
REQ-010 compute_done  output  1  deal complete; held high while start stays high.
REQ-011 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-012 States SHALL be IDLE, FILL, PICK, RD_I, RD_J, RD_WAIT, WR_I, WR_J, DONE.
REQ-013 IDLE->FILL on the start rising edge; latch N = min(num_of_cards & ~1, 30); if N==0 go to DONE instead.
REQ-014 FILL SHALL write addresses k=1..N, one per cycle, color = PALETTE[(k-1)>>1], state 2'b01; after k==N set i=N and go to PICK.
REQ-015 16-bit LFSR, x^16+x^14+x^13+x^11+1, SHALL reset to 16'hACE1 and advance every cycle in every state.
REQ-016 PICK: cand = lfsr[4:0]; if cand < i then j = cand+1 and go to RD_I; otherwise stay in PICK (rejection, no modulo).
REQ-017 RD_I presents i and RD_J presents j; color_i is captured in RD_J and color_j in RD_WAIT; mem_we stays low in all three states.
REQ-018 WR_I SHALL write color_j to i, and WR_J SHALL write color_i to j; i==j is legal and leaves the card unchanged.
REQ-019 After WR_J: i = i-1; if i==1 go to DONE, else go to PICK.
REQ-020 Latency: FILL takes N cycles; each swap takes 6 cycles plus rejected PICK cycles.
REQ-021 DONE: compute_done=1; DONE->IDLE when start is low.
REQ-022 start low in any busy state SHALL abort to IDLE next cycle with no further writes; memory contents are then undefined.
REQ-023 mem_we is asserted only in FILL, WR_I and WR_J; mem_addr is held at 0 in IDLE and DONE.
REQ-024 The final memory content SHALL be a permutation of the FILL content: every PALETTE entry 0..N/2-1 appears exactly twice.

Reset
REQ-025 rst SHALL force state=IDLE, mem_we=0, mem_addr=0, mem_wdata_color=0, mem_wdata_state=2'b01, compute_done=0, busy=0, lfsr=16'hACE1, i=j=N=0.
REQ-026 rst asserted mid-deal SHALL take effect immediately; after release the block waits for a fresh start rising edge.

Structure
REQ-027 CARD_ADDRESS_SIZE, CARD_COLOR_SIZE, CARD_STATE_SIZE, CARD_MAX_NUM_SIZE, the 15-entry PALETTE and the covered-state code SHALL live in the shared cards macros header.
REQ-028 The LFSR SHALL be a sub-module named lfsr16 (clk, rst, q[15:0]).

Verification
REQ-029 N=4, start held -> writes (1,P0),(2,P0),(3,P1),(4,P1) on 4 consecutive cycles, then 3 swaps; final memory holds {P0,P0,P1,P1}; compute_done high.
REQ-030 num_of_cards=0 -> DONE in 1 cycle, no mem_we pulses, compute_done=1.
REQ-031 num_of_cards=5 -> N=4; address 5 never written; num_of_cards=31 -> N=30, 15 colors, each appearing twice.
REQ-032 start dropped 2 cycles into PICK -> IDLE next cycle, no further mem_we, compute_done stays 0; a new start completes normally.
REQ-033 rst pulsed during RD_WAIT -> all outputs at reset values asynchronously; lfsr==16'hACE1 after release.
REQ-034 Scoreboard over 50 random-length starts -> every swap has 1<=j<=i, writes happen only in WR_I and WR_J, and the pair-count property of REQ-024 holds.
